shift_issue_stage: RTL and testbench
====================================

SHIFT_ISSUE_STAGE -- requirements
Module: shift_issue_stage

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high; ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 flush  input  1  discards all held entries at the next edge.
REQ-005 in_valid  input  1  upstream offers a shift instruction.
REQ-006 in_ready  output  1  stage can accept an instruction this cycle.
REQ-007 in_funct3  input  3  instruction funct3.
REQ-008 in_funct7_5  input  1  instruction bit 30 (arith/logical select).
REQ-009 in_is_imm  input  1  1 = immediate form (SLLI/SRLI/SRAI), 0 = register form.
REQ-010 in_rs1  input  32  shift source operand.
REQ-011 in_rs2  input  32  register shift amount source.
REQ-012 in_imm  input  12  I-type immediate field.
REQ-013 in_rd  input  5  destination register tag.
REQ-014 out_valid  output  1  head entry is presented to the shifter.
REQ-015 out_ready  input  1  downstream consumes the head entry.
REQ-016 out_a  output  32  shifter operand a.
REQ-017 out_shamt  output  5  shifter shift amount.
REQ-018 out_type  output  2  shifter type: 00 SLL, 01 SRL, 10 SRA, 11 invalid (shifter yields 0).
REQ-019 out_rd  output  5  destination tag carried with the operation.
REQ-020 out_illegal  output  1  entry decoded as an illegal shift encoding.

Function
REQ-021 Decode SHALL be: funct3=001 & funct7_5=0 -> 00; funct3=101 & funct7_5=0 -> 01; funct3=101 & funct7_5=1 -> 10; anything else -> type 11 with illegal=1.
REQ-022 For in_is_imm=1, illegal SHALL also be set (type 11) when in_imm[11] or any of in_imm[9:5] is 1.
REQ-023 shamt SHALL be in_imm[4:0] when in_is_imm=1, else in_rs2[4:0]; upper bits ignored.
REQ-024 Storage SHALL be a 2-entry FIFO holding {a, shamt, type, rd, illegal}; occupancy states EMPTY, ONE, FULL.
REQ-025 Push occurs on an edge where in_valid & in_ready; pop on an edge where out_valid & out_ready.
REQ-026 in_ready SHALL be 1 iff state != FULL and rst=0; it SHALL NOT depend combinationally on out_ready.
REQ-027 out_valid SHALL be 1 iff state != EMPTY; out_* SHALL show the oldest entry.
REQ-028 Latency: an instruction pushed at edge N SHALL appear on out_* with out_valid=1 immediately after edge N (no combinational in->out path).
REQ-029 Transitions: EMPTY+push -> ONE; ONE+push-only -> FULL; ONE+pop-only -> EMPTY; ONE+push+pop -> ONE (new entry becomes head); FULL+pop -> ONE.
REQ-030 Order SHALL be strictly FIFO; no entry is duplicated or lost except by flush or reset.
REQ-031 While out_valid=1 and out_ready=0, out_* SHALL remain stable.
REQ-032 flush SHALL force state EMPTY at the next edge, taking priority over a same-cycle push and pop; the offered instruction is dropped.
REQ-033 Illegal entries SHALL flow through the FIFO like legal ones; no trap is raised here.

Reset
REQ-034 With rst=1 at an edge: state EMPTY, out_valid=0, out_a=0, out_shamt=0, out_type=00, out_rd=0, out_illegal=0; in_ready=0 while rst=1.
REQ-035 rst SHALL take priority over flush, push and pop; a reset mid-operation discards all entries.

Verification
REQ-036 Reset then push SRAI: rs1=0x80000000, imm=0x404 -> next cycle out_valid=1, out_a=0x80000000, shamt=4, type=10, illegal=0.
REQ-037 Register SLL: rs2=0xFFFFFF23, funct3=001, funct7_5=0 -> shamt=3, type=00; shamt upper bits ignored.
REQ-038 out_ready=0, push three ops A,B,C -> A,B held, in_ready=0 after second push, C not accepted; release out_ready -> A then B emitted in order.
REQ-039 State ONE, push and pop on the same edge -> remains ONE, new entry at head, in_ready=1 throughout.
REQ-040 funct3=000, or SLLI with imm=0x420 -> type=11, illegal=1.
REQ-041 FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered op dropped; repeat with rst mid-stream -> all outputs 0.

Source files
------------

// File: rtl/shift_issue_stage.sv
// Shift issue stage: decodes RV32 shift instructions into shifter controls and
// buffers them in a 2-entry FIFO whose head drives the shifter directly.
module shift_issue_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7_5,
  input  logic              in_is_imm,
  input  logic [DATA_W-1:0] in_rs1,
  input  logic [31:0]       in_rs2,
  input  logic [11:0]       in_imm,
  input  logic [4:0]        in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [4:0]        out_shamt,
  output logic [1:0]        out_type,
  output logic [4:0]        out_rd,
  output logic              out_illegal
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [4:0]        shamt;
    logic [1:0]        typ;
    logic [4:0]        rd;
    logic              illegal;
  } entry_t;

  localparam logic [1:0] TYPE_SLL = 2'b00;
  localparam logic [1:0] TYPE_SRL = 2'b01;
  localparam logic [1:0] TYPE_SRA = 2'b10;
  localparam logic [1:0] TYPE_BAD = 2'b11;

  // Immediate bit 10 duplicates funct7_5, so only bits 11 and 9:5 are checked.
  function automatic entry_t decode_op(
    input logic [2:0]        funct3,
    input logic              funct7_5,
    input logic              is_imm,
    input logic [DATA_W-1:0] rs1,
    input logic [31:0]       rs2,
    input logic [11:0]       imm,
    input logic [4:0]        rd
  );
    entry_t e;
    e.a       = rs1;
    e.rd      = rd;
    e.shamt   = is_imm ? imm[4:0] : rs2[4:0];
    e.illegal = 1'b0;
    if (funct3 == 3'b001 && !funct7_5) begin
      e.typ = TYPE_SLL;
    end else if (funct3 == 3'b101) begin
      e.typ = funct7_5 ? TYPE_SRA : TYPE_SRL;
    end else begin
      e.typ     = TYPE_BAD;
      e.illegal = 1'b1;
    end
    if (is_imm && (imm[11] || (|imm[9:5]))) begin
      e.typ     = TYPE_BAD;
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  state_t state;
  entry_t new_entry;
  entry_t slot_p0;   // head, drives the shifter
  entry_t slot_p1;   // second-oldest entry, valid only in FULL
  logic   vld_p0;
  logic   push;
  logic   pop;

  assign new_entry = decode_op(in_funct3, in_funct7_5, in_is_imm, in_rs1,
                               in_rs2, in_imm, in_rd);

  assign vld_p0   = (state != EMPTY);
  assign in_ready = (state != FULL) && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = vld_p0 && out_ready;

  // Stage p0: occupancy control and entry storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      slot_p0 <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            slot_p0 <= new_entry;
            state   <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            slot_p0 <= new_entry;
          end else if (push) begin
            slot_p1 <= new_entry;
            state   <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            slot_p0 <= slot_p1;
            state   <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_valid   = vld_p0;
  assign out_a       = slot_p0.a;
  assign out_shamt   = slot_p0.shamt;
  assign out_type    = slot_p0.typ;
  assign out_rd      = slot_p0.rd;
  assign out_illegal = slot_p0.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage: decode, FIFO ordering, backpressure,
// flush and reset behaviour against hand-computed values.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic        in_is_imm;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [11:0] in_imm;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [4:0]  out_shamt;
  logic [1:0]  out_type;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  shift_issue_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_funct7_5(in_funct7_5), .in_is_imm(in_is_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_shamt(out_shamt), .out_type(out_type),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] f3, input logic f7, input logic imm_form,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [11:0] imm, input logic [4:0] rd);
    in_funct3   = f3;
    in_funct7_5 = f7;
    in_is_imm   = imm_form;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_imm      = imm;
    in_rd       = rd;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] a,
                           input logic [4:0] sh, input logic [1:0] ty,
                           input logic [4:0] rd, input logic ill);
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".a"}, 64'(out_a), 64'(a));
    check({tag, ".shamt"}, 64'(out_shamt), 64'(sh));
    check({tag, ".type"}, 64'(out_type), 64'(ty));
    check({tag, ".rd"}, 64'(out_rd), 64'(rd));
    check({tag, ".illegal"}, 64'(out_illegal), 64'(ill));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_op(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 12'h0, 5'd0);
    step();
    step();
    check_out("reset", 1'b0, 32'h0, 5'd0, 2'b00, 5'd0, 1'b0);
    check("reset.in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("post_reset.in_ready", 64'(in_ready), 64'd1);

    // SRAI x7, rs1=0x80000000, shamt 4
    set_op(3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 12'h404, 5'd7);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_out("srai", 1'b1, 32'h8000_0000, 5'd4, 2'b10, 5'd7, 1'b0);
    check("srai.in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    check("srai_pop.valid", 64'(out_valid), 64'd0);

    // Register SLL, only rs2[4:0] used
    out_ready = 1'b0;
    set_op(3'b001, 1'b0, 1'b0, 32'h1234_5678, 32'hFFFF_FF23, 12'hFFF, 5'd3);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_out("sll", 1'b1, 32'h1234_5678, 5'd3, 2'b00, 5'd3, 1'b0);
    out_ready = 1'b1;
    step();
    check("sll_pop.valid", 64'(out_valid), 64'd0);

    // Illegal funct3=000, held in ONE
    out_ready = 1'b0;
    set_op(3'b000, 1'b0, 1'b0, 32'hAAAA_0001, 32'h5, 12'h0, 5'd11);
    in_valid = 1'b1;
    step();
    check_out("f3_000", 1'b1, 32'hAAAA_0001, 5'd5, 2'b11, 5'd11, 1'b1);

    // Push+pop in ONE: illegal SLLI imm=0x420 replaces head
    out_ready = 1'b1;
    set_op(3'b001, 1'b0, 1'b1, 32'hBBBB_0002, 32'h1F, 12'h420, 5'd12);
    check("pp1.in_ready_before", 64'(in_ready), 64'd1);
    step();
    check_out("slli_bad", 1'b1, 32'hBBBB_0002, 5'd0, 2'b11, 5'd12, 1'b1);
    check("pp1.in_ready_after", 64'(in_ready), 64'd1);

    // Push+pop again: SRLI shamt 31
    set_op(3'b101, 1'b0, 1'b1, 32'h0000_00F0, 32'h0, 12'h01F, 5'd9);
    step();
    in_valid = 1'b0;
    check_out("srli", 1'b1, 32'h0000_00F0, 5'd31, 2'b01, 5'd9, 1'b0);
    check("pp2.in_ready", 64'(in_ready), 64'd1);
    step();
    check("pp_drain.valid", 64'(out_valid), 64'd0);

    // Backpressure: A, B held, C refused, then drained in order
    out_ready = 1'b0;
    set_op(3'b001, 1'b0, 1'b0, 32'h0000_000A, 32'h1, 12'h0, 5'd1);
    in_valid = 1'b1;
    step();
    check("bp.in_ready_one", 64'(in_ready), 64'd1);
    set_op(3'b101, 1'b0, 1'b0, 32'h0000_000B, 32'h2, 12'h0, 5'd2);
    step();
    check("bp.in_ready_full", 64'(in_ready), 64'd0);
    check_out("bp_hold_a", 1'b1, 32'h0000_000A, 5'd1, 2'b00, 5'd1, 1'b0);
    set_op(3'b101, 1'b1, 1'b0, 32'h0000_000C, 32'h3, 12'h0, 5'd3);
    step();
    check_out("bp_still_a", 1'b1, 32'h0000_000A, 5'd1, 2'b00, 5'd1, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check_out("bp_b", 1'b1, 32'h0000_000B, 5'd2, 2'b01, 5'd2, 1'b0);
    check("bp.in_ready_after_pop", 64'(in_ready), 64'd1);
    step();
    check("bp_c_dropped.valid", 64'(out_valid), 64'd0);

    // Flush in FULL with an offered op
    out_ready = 1'b0;
    in_valid = 1'b1;
    set_op(3'b001, 1'b0, 1'b0, 32'h1, 32'h1, 12'h0, 5'd1);
    step();
    step();
    check("fl.full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    set_op(3'b101, 1'b0, 1'b0, 32'hD, 32'h4, 12'h0, 5'd4);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_full.valid", 64'(out_valid), 64'd0);
    check("fl_full.in_ready", 64'(in_ready), 64'd1);

    // Flush in ONE beats a same-cycle push and pop
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    flush = 1'b1;
    out_ready = 1'b1;
    set_op(3'b101, 1'b1, 1'b0, 32'hE, 32'h6, 12'h0, 5'd6);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_one.valid", 64'(out_valid), 64'd0);

    // Reset mid-stream from FULL
    out_ready = 1'b0;
    in_valid = 1'b1;
    set_op(3'b101, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0, 12'h41F, 5'd31);
    step();
    step();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    check_out("rst_mid", 1'b0, 32'h0, 5'd0, 2'b00, 5'd0, 1'b0);
    check("rst_mid.in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_release.in_ready", 64'(in_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
